// File: rtl/logit8_piped.sv
// logit8_piped: 4-stage pipelined logit (inverse of the 9-segment PWL sigmoid), sign-magnitude Q4.15.
// Defining LOGIT8_PIPED_RANGE_ERR_EN adds the range_err and err_cnt outputs.
module logit8_piped #(
    parameter int unsigned BITSIZE = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] data_out
`ifdef LOGIT8_PIPED_RANGE_ERR_EN
    ,
    output logic               range_err,
    output logic [7:0]         err_cnt
`endif
);

    // y breakpoints yb1..yb8 in Q15
    function automatic logic [14:0] yb_f(input logic [3:0] k);
        case (k)
            4'd1:    return 15'd377;
            4'd2:    return 15'd1652;
            4'd3:    return 15'd4221;
            4'd4:    return 15'd8536;
            4'd5:    return 15'd24232;
            4'd6:    return 15'd28547;
            4'd7:    return 15'd31116;
            default: return 15'd32391;
        endcase
    endfunction

    function automatic logic signed [19:0] xb_f(input logic [3:0] k);
        case (k)
            4'd1:    return -20'sd145581;
            4'd2:    return -20'sd96145;
            4'd3:    return -20'sd62681;
            4'd4:    return -20'sd34200;
            4'd5:    return 20'sd34200;
            4'd6:    return 20'sd62682;
            4'd7:    return 20'sd96144;
            default: return 20'sd145583;
        endcase
    endfunction

    // Inverse slopes 1/m_k as unsigned Q9.15
    function automatic logic [23:0] s_f(input logic [3:0] seg);
        case (seg)
            4'd1, 4'd9: return 24'd10240000;
            4'd2, 4'd8: return 24'd1270078;
            4'd3, 4'd7: return 24'd428340;
            4'd4, 4'd6: return 24'd216148;
            default:    return 24'd142780;
        endcase
    endfunction

    function automatic logic [3:0] anc_f(input logic [3:0] seg);
        return (seg <= 4'd1) ? 4'd1 : seg - 4'd1;
    endfunction

    logic              en;
    logic [18:0]       in_mag;
    logic              in_lo, in_hi;
    logic [3:0]        seg_in;

    logic              v1_q, lo1_q, hi1_q;
    logic [14:0]       y1_q;
    logic [3:0]        seg1_q;
    logic              v2_q, lo2_q, hi2_q;
    logic signed [16:0] diff2_d, diff2_q;
    logic [3:0]        seg2_q;
    logic              v3_q, lo3_q, hi3_q;
    logic signed [41:0] prod3_d, prod3_q;
    logic [3:0]        seg3_q;
    logic              out_valid_q;
    logic [BITSIZE-1:0] data_out_d, data_out_q;

    logic signed [41:0] diff_ext, slope_ext;
    logic signed [41:0] prod_adj, quot, sum;
    logic signed [19:0] xb;
    logic [41:0]       abs_v;
    logic [18:0]       mag;
    logic              neg;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign in_mag   = data_in[BITSIZE-2:0];
    // y <= 0 (including -0) and y >= 1.0 bypass the datapath
    assign in_lo    = data_in[BITSIZE-1] || (in_mag == 19'd0);
    assign in_hi    = !data_in[BITSIZE-1] && (in_mag >= 19'h08000);

    always_comb begin
        seg_in = 4'd1;
        for (int k = 1; k <= 8; k++) begin
            if (in_mag >= {4'd0, yb_f(4'(k))}) seg_in = seg_in + 4'd1;
        end
    end

    always_comb begin
        diff2_d = $signed({2'b00, y1_q}) - $signed({2'b00, yb_f(anc_f(seg1_q))});
    end

    always_comb begin
        diff_ext  = {{25{diff2_q[16]}}, diff2_q};
        slope_ext = {18'd0, s_f(seg2_q)};
        prod3_d   = diff_ext * slope_ext;
    end

    always_comb begin
        // bias negative products so the shift truncates toward zero
        prod_adj = prod3_q;
        if (prod3_q[41]) prod_adj = prod3_q + 42'sd32767;
        quot  = prod_adj >>> 15;
        xb    = xb_f(anc_f(seg3_q));
        sum   = quot + {{22{xb[19]}}, xb};
        neg   = sum[41];
        abs_v = neg ? -sum : sum;
        mag   = (abs_v > 42'h7FFFF) ? 19'h7FFFF : abs_v[18:0];
        data_out_d = {neg && (mag != 19'd0), mag};
        if (lo3_q)      data_out_d = 20'hFFFFF;
        else if (hi3_q) data_out_d = 20'h7FFFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0; lo1_q <= 1'b0; hi1_q <= 1'b0; y1_q <= '0; seg1_q <= 4'd1;
            v2_q <= 1'b0; lo2_q <= 1'b0; hi2_q <= 1'b0; diff2_q <= '0; seg2_q <= 4'd1;
            v3_q <= 1'b0; lo3_q <= 1'b0; hi3_q <= 1'b0; prod3_q <= '0; seg3_q <= 4'd1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else if (en) begin
            v1_q   <= in_valid;
            lo1_q  <= in_lo;
            hi1_q  <= in_hi;
            y1_q   <= in_mag[14:0];
            seg1_q <= seg_in;
            v2_q    <= v1_q;
            lo2_q   <= lo1_q;
            hi2_q   <= hi1_q;
            diff2_q <= diff2_d;
            seg2_q  <= seg1_q;
            v3_q    <= v2_q;
            lo3_q   <= lo2_q;
            hi3_q   <= hi2_q;
            prod3_q <= prod3_d;
            seg3_q  <= seg2_q;
            out_valid_q <= v3_q;
            if (v3_q) data_out_q <= data_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

`ifdef LOGIT8_PIPED_RANGE_ERR_EN
    logic       rerr_q;
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rerr_q    <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            if (en && v3_q) rerr_q <= lo3_q || hi3_q;
            if (out_valid_q && out_ready && rerr_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign range_err = rerr_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_logit8_piped.sv
// Scoreboard bench for logit8_piped: real-valued logit model, latency, stall and reset checks.
module tb_logit8_piped;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] data_out;
`ifdef LOGIT8_PIPED_RANGE_ERR_EN
    logic        range_err;
    logic [7:0]  err_cnt;
`endif

    logit8_piped #(.BITSIZE(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
`ifdef LOGIT8_PIPED_RANGE_ERR_EN
        ,
        .range_err (range_err),
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int exp;
        int tol;
        bit exact;
        bit rng;
        bit lat;
        int acc;
    } exp_t;

    exp_t sb[$];

    real xb_r [0:7] = '{-4.44277, -2.93411, -1.91286, -1.04370, 1.04370, 1.91290, 2.93409, 4.44283};
    real yb_r [0:7] = '{0.0115, 0.0504, 0.1288, 0.2605, 0.7395, 0.8712, 0.9496, 0.9885};
    real m_r  [0:8] = '{0.0032, 0.0258, 0.0765, 0.1516, 0.2295, 0.1516, 0.0765, 0.0258, 0.0032};
    int  yb_c [0:7];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int err_exp = 0;
    bit started = 0;
    bit acc_now = 0;
    bit prev_stall = 0;
    bit no_gap = 0;
    bit lat_chk = 0;
    bit ovr_en = 0;
    int ovr_exp = 0;
    int ovr_tol = 0;
    logic [19:0] prev_data;

    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        int d;
        d = got - exp;
        if (d < 0) d = -d;
        n_total++;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d at cycle %0d",
                     tag, got, got, exp, exp, tol, cyc);
        end
    endtask

    function automatic int sm2int(input logic [19:0] v);
        return v[19] ? -int'(v[18:0]) : int'(v[18:0]);
    endfunction

    function automatic bit is_rng(input logic [19:0] d);
        return d[19] || (d[18:0] == 19'd0) || (d[18:0] >= 19'h08000);
    endfunction

    // x = xb + (y - yb) / m in reals, rounded to the nearest Q15 LSB
    function automatic int model(input logic [19:0] d);
        int  mag;
        int  j;
        int  a;
        real x;
        mag = int'(d[18:0]);
        j = 1;
        for (int k = 0; k < 8; k++) if (yb_c[k] <= mag) j++;
        a = (j == 1) ? 0 : j - 2;
        x = xb_r[a] + (real'(mag - yb_c[a]) / 32768.0) / m_r[j-1];
        x = x * 32768.0;
        if (x > 524287.0) x = 524287.0;
        if (x < -524287.0) x = -524287.0;
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("spurious", int'(out_valid), 0, 0);
        end else begin
            e = sb.pop_front();
            if (e.exact) check_val("sat", int'(data_out), e.exp, 0);
            else         check_val("value", sm2int(data_out), e.exp, e.tol);
            check_val("negzero", int'(data_out == 20'h80000), 0, 0);
            if (e.lat) check_val("latency", cyc - e.acc, 4, 0);
`ifdef LOGIT8_PIPED_RANGE_ERR_EN
            check_val("range_err", int'(range_err), int'(e.rng), 0);
            if (e.rng && err_exp < 255) err_exp++;
`endif
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.acc = cyc;
        e.lat = lat_chk;
        e.tol = 0;
        if (is_rng(data_in)) begin
            e.exact = 1;
            e.rng   = 1;
            e.exp   = (data_in[19] || data_in[18:0] == 19'd0) ? 'hFFFFF : 'h7FFFF;
        end else begin
            e.exact = 0;
            e.rng   = 0;
            e.exp   = model(data_in);
            e.tol   = 4;
        end
        if (ovr_en) begin
            e.exact = 0;
            e.exp   = ovr_exp;
            e.tol   = ovr_tol;
        end
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        acc_now = 0;
        if (!reset && started) begin
            if (prev_stall) begin
                check_val("hold_valid", int'(out_valid), 1, 0);
                check_val("hold_data", int'(data_out), int'(prev_data), 0);
            end
            if (!out_valid)      check_val("rdy_idle", int'(in_ready), 1, 0);
            else if (!out_ready) check_val("rdy_stall", int'(in_ready), 0, 0);
            if (no_gap && sb.size() > 0) check_val("gap", int'(out_valid), 1, 0);
            if (out_valid && out_ready) pop_check();
            if (in_valid && in_ready) begin
                push_exp();
                acc_now = 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = data_out;
        end else begin
            prev_stall = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send1(input logic [19:0] d);
        bit got_acc;
        got_acc  = 0;
        in_valid = 1'b1;
        data_in  = d;
        for (int t = 0; t < 20 && !got_acc; t++) begin
            step();
            got_acc = acc_now;
        end
        in_valid = 1'b0;
        check_val("accepted", int'(got_acc), 1, 0);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 60 && sb.size() > 0; t++) step();
        step();
        step();
        check_val("drain", sb.size(), 0, 0);
    endtask

    initial begin
        logic [19:0] sweep [0:9];
        int n;
        sweep = '{20'h00064, 20'h003E8, 20'h00BB8, 20'h01770, 20'h02EE0,
                  20'h04E20, 20'h06590, 20'h07530, 20'h07D00, 20'h07FFF};
        for (int k = 0; k < 8; k++) yb_c[k] = $rtoi(yb_r[k] * 32768.0 + 0.5);

        reset = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
        step();
        step();
        check_val("rst_in_ready", int'(in_ready), 1, 0);
        reset = 1'b0;
        check_val("rst_out_valid", int'(out_valid), 0, 0);
        check_val("rst_data_out", int'(data_out), 0, 0);
`ifdef LOGIT8_PIPED_RANGE_ERR_EN
        check_val("rst_err_cnt", int'(err_cnt), 0, 0);
`endif
        started = 1;

        // y = 0.5 lands at x ~ 0 with exact 4-cycle latency
        lat_chk = 1; ovr_en = 1; ovr_exp = 0; ovr_tol = 16;
        send1(20'h04000);
        drain();
        // breakpoints yb5 / yb4 map to +/-1.0437
        ovr_exp = 34208; ovr_tol = 32;
        send1(20'h05EA8);
        ovr_exp = -34208;
        send1(20'h02158);
        ovr_en = 0;
        drain();

        // one sample per segment, back to back
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = sweep[i];
            step();
            check_val("sweep_acc", int'(acc_now), 1, 0);
        end
        drain();
        lat_chk = 0;

        send1(20'h00000);
        send1(20'h08000);
        send1(20'h80123);
        drain();
`ifdef LOGIT8_PIPED_RANGE_ERR_EN
        check_val("err_cnt3", int'(err_cnt), 3, 0);
`endif
        send1(20'h80000);
        send1(20'h0FFFF);
        drain();

        // 10 back-to-back samples with a 5-cycle downstream stall
        n = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && n < 10; i++) begin
            out_ready = !(i >= 4 && i < 9);
            no_gap    = (i >= 9);
            data_in   = {5'd0, 15'(1000 + 3000 * n)};
            step();
            if (acc_now) n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_val("b2b_count", n, 10, 0);
        drain();
        no_gap = 0;

        // random traffic and backpressure, including out-of-range inputs
        in_valid = 1'b0;
        acc_now  = 0;
        for (int i = 0; i < 120; i++) begin
            if (!in_valid || acc_now) begin
                int r;
                r = int'($urandom_range(0, 7));
                in_valid = 1'($urandom_range(0, 1));
                if (r == 0)      data_in = {1'b1, 19'($urandom_range(0, 524287))};
                else if (r == 1) data_in = {1'b0, 4'($urandom_range(1, 15)), 15'($urandom)};
                else             data_in = {5'd0, 15'($urandom_range(1, 32767))};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
`ifdef LOGIT8_PIPED_RANGE_ERR_EN
        check_val("err_cnt", int'(err_cnt), err_exp, 0);
`endif

        // reset with three samples in flight discards them
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = {5'd0, 15'(5000 + 7000 * i)};
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        err_exp = 0;
        check_val("rst_mid_valid", int'(out_valid), 0, 0);
`ifdef LOGIT8_PIPED_RANGE_ERR_EN
        check_val("rst_mid_err_cnt", int'(err_cnt), 0, 0);
`endif
        for (int i = 0; i < 6; i++) step();
        lat_chk = 1;
        send1(20'h01234);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
